adder_seq_ctrl: RTL and testbench

ADDER_SEQ_CTRL -- requirements
Module: adder_seq_ctrl

---
 rtl/adder_seq_ctrl.sv | 109 ++++++++++
 tb/tb_adder_seq_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_seq_ctrl.sv
// Sequences a W-bit add through one shared SLICE_W-bit external adder slice, LSB slice first.
// Latency NSLICE+1 cycles from accepted start to done; start is ignored while busy (no queueing).
// Optional ADDER_SEQ_ERRCNT_EN adds err_cnt, a saturating count of inexact slice results.
module adder_seq_ctrl #(
  parameter int SLICE_W = 3,
  parameter int NSLICE  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [SLICE_W*NSLICE-1:0]   a,
  input  logic [SLICE_W*NSLICE-1:0]   b,
  input  logic                        cin,
  output logic                        busy,
  output logic                        done,
  output logic [SLICE_W*NSLICE-1:0]   sum,
  output logic                        cout,
`ifdef ADDER_SEQ_ERRCNT_EN
  output logic [7:0]                  err_cnt,
`endif
  output logic [SLICE_W-1:0]          slice_a,
  output logic [SLICE_W-1:0]          slice_b,
  output logic                        slice_cin,
  input  logic [SLICE_W-1:0]          slice_s,
  input  logic                        slice_cout
);

  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                          state;
  logic [NSLICE-1:0][SLICE_W-1:0]  a_reg;
  logic [NSLICE-1:0][SLICE_W-1:0]  b_reg;
  logic [NSLICE-1:0][SLICE_W-1:0]  sum_reg;
  logic [IW-1:0]                   idx;
  logic                            carry;
  logic                            accept;

  assign accept = start && (state != RUN);
  assign sum    = sum_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      idx     <= '0;
      carry   <= 1'b0;
      cout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_reg   <= a;
        b_reg   <= b;
        carry   <= cin;
        sum_reg <= '0;
        cout    <= 1'b0;
        idx     <= '0;
        state   <= RUN;
        busy    <= 1'b1;
      end else if (state == RUN) begin
        sum_reg[idx] <= slice_s;
        carry        <= slice_cout;
        if (idx == LAST) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          cout  <= slice_cout;
          idx   <= '0;
        end else begin
          idx <= idx + IW'(1);
        end
      end else begin
        state <= IDLE;
      end
    end
  end

  // Slice inputs are quiet outside RUN so the external slice sees no activity.
  always_comb begin
    slice_a   = '0;
    slice_b   = '0;
    slice_cin = 1'b0;
    if (state == RUN) begin
      slice_a   = a_reg[idx];
      slice_b   = b_reg[idx];
      slice_cin = carry;
    end
  end

`ifdef ADDER_SEQ_ERRCNT_EN
  logic [SLICE_W:0] exact;
  assign exact = {1'b0, slice_a} + {1'b0, slice_b} + {{SLICE_W{1'b0}}, slice_cin};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (state == RUN && {slice_cout, slice_s} != exact && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Randomized scoreboard bench for adder_seq_ctrl with a behavioural slice model that can inject LSB errors.
module tb_adder_seq_ctrl;
  localparam int SW = 3;
  localparam int NS = 4;
  localparam int W  = SW * NS;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  a, b;
  logic          cin;
  logic          busy, done, cout;
  logic [W-1:0]  sum;
  logic [SW-1:0] slice_a, slice_b, slice_s;
  logic          slice_cin, slice_cout;
`ifdef ADDER_SEQ_ERRCNT_EN
  logic [7:0]    err_cnt;
`endif

  adder_seq_ctrl #(.SLICE_W(SW), .NSLICE(NS)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout),
`ifdef ADDER_SEQ_ERRCNT_EN
    .err_cnt(err_cnt),
`endif
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
    .slice_s(slice_s), .slice_cout(slice_cout)
  );

  always #5 clk = ~clk;

  // External slice: exact adder, optionally flipping the sum LSB.
  logic          err_mode = 1'b0;
  logic [SW:0]   slice_ex;
  always_comb begin
    slice_ex   = {1'b0, slice_a} + {1'b0, slice_b} + {{SW{1'b0}}, slice_cin};
    slice_s    = slice_ex[SW-1:0] ^ (err_mode ? SW'(1) : SW'(0));
    slice_cout = slice_ex[SW];
  end

  typedef struct packed {
    logic [W:0] res;
    logic [7:0] err;
  } exp_t;

  exp_t       q[$];
  int         n_chk  = 0;
  int         n_pass = 0;
  int         m_state = 0;   // 0 idle, 1 run, 2 done
  int         m_rem   = 0;
  int         m_err   = 0;
  logic [W:0] m_last  = '0;
  logic [W:0] m_pend  = '0;
  logic       started = 1'b0;

  // Whole-word sum; an erring slice flips the LSB of each slice field but its carry stays exact.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic e);
    logic [W:0] r;
    logic [W:0] mask;
    r    = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    mask = '0;
    for (int i = 0; i < NS; i++) mask = mask | ((W+1)'(1) << (i * SW));
    return e ? (r ^ mask) : r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) begin
      if (m_state == 1) begin
        m_rem--;
        if (m_rem == 0) begin
          m_state = 2;
          m_last  = m_pend;
        end
      end else if (start) begin
        if (err_mode) m_err = (m_err + NS > 255) ? 255 : m_err + NS;
        m_pend  = ref_add(a, b, cin, err_mode);
        m_last  = '0;
        q.push_back('{res: m_pend, err: 8'(m_err)});
        m_state = 1;
        m_rem   = NS;
      end else begin
        m_state = 0;
      end
    end
    #1;
  endtask

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    a = x; b = y; cin = c; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_state(input int s);
    int n = 0;
    while (m_state != s && n < 50) begin
      step();
      n++;
    end
    chk("wait_bound", 32'(m_state), 32'(s));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    m_state = 0; m_rem = 0; m_err = 0; m_last = '0;
    q.delete();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum",  32'(sum),  32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
`ifdef ADDER_SEQ_ERRCNT_EN
    chk("rst_errcnt", 32'(err_cnt), 32'd0);
`endif
    #1;
    rst = 1'b0;
  endtask

  // Monitor: cycle-level state checks plus scoreboard pop on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (started && !rst) begin
      chk("busy", 32'(busy), 32'(m_state == 1));
      chk("done", 32'(done), 32'(m_state == 2));
      if (m_state != 1) begin
        chk("slice_a_quiet", 32'(slice_a), 32'd0);
        chk("slice_b_quiet", 32'(slice_b), 32'd0);
        chk("slice_cin_quiet", 32'(slice_cin), 32'd0);
        chk("hold", 32'({cout, sum}), 32'(m_last));
      end
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("result", 32'({cout, sum}), 32'(e.res));
`ifdef ADDER_SEQ_ERRCNT_EN
          chk("err_cnt", 32'(err_cnt), 32'(e.err));
`endif
        end
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #2;
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_done", 32'(done), 32'd0);
    chk("init_sum",  32'({cout, sum}), 32'd0);
    chk("init_slice", 32'({slice_a, slice_b, slice_cin}), 32'd0);
    #10;
    rst = 1'b0;
    started = 1'b1;

    // Basic add; a second start during RUN must be ignored.
    issue(12'h123, 12'h456, 1'b0);
    step();
    a = 12'h111; b = 12'h111; start = 1'b1;
    step();
    start = 1'b0;
    wait_state(2);
    chk("sum_0x579", 32'(sum), 32'h579);
    // Start in the DONE cycle goes straight back to RUN.
    issue(12'hFFF, 12'h001, 1'b0);
    chk("b2b_run", 32'(m_state), 32'd1);
    wait_state(0);
    issue(12'hFFF, 12'h000, 1'b1);
    wait_state(0);
    chk("cin_wrap", 32'({cout, sum}), 32'h1000);

    // Reset mid-operation at index 2 abandons it.
    issue(12'h123, 12'h456, 1'b0);
    step();
    step();
    pulse_reset();
    step();
    issue(12'h001, 12'h001, 1'b0);
    wait_state(0);
    chk("post_rst_sum", 32'(sum), 32'h002);

    // Erroneous slice for 64 operations, then exact ones.
    pulse_reset();
    err_mode = 1'b1;
    for (int i = 0; i < 64; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom));
      wait_state(0);
    end
    err_mode = 1'b0;
    issue(W'($urandom), W'($urandom), 1'($urandom));
    wait_state(0);
`ifdef ADDER_SEQ_ERRCNT_EN
    chk("err_sat", 32'(err_cnt), 32'd255);
`endif

    // Random traffic: starts land in IDLE, RUN and DONE cycles.
    pulse_reset();
    for (int i = 0; i < 1500; i++) begin
      if (m_state != 1 && ($urandom % 8) == 0) err_mode = 1'($urandom);
      start = (($urandom % 3) == 0);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      step();
    end
    start = 1'b0;
    wait_state(0);
    step();
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
